// File: rtl/hard_mem_1rw_arb_ctrl_pkg.sv
// Shared types for the 1RW memory arbiter/init sequencer.
package hard_mem_arb_ctrl_pkg;
  localparam int num_req_lp = 2;
  typedef enum logic {e_init, e_run} state_e;
endpackage

// File: rtl/hard_mem_1rw_arb_ctrl_rr2.sv
// Two-input round-robin arbiter; rr_last only moves when both inputs contend.
module hard_mem_arb_rr2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] v_i,
  output logic [1:0] grant_o
);
  logic rr_last_r;

  always_comb begin
    grant_o = 2'b00;
    unique case (v_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = rr_last_r ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  // Reset value 1 lets requester 0 win the first contention.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)    rr_last_r <= 1'b1;
    else if (&v_i)  rr_last_r <= grant_o[1];
  end
endmodule

// File: rtl/hard_mem_1rw_arb_ctrl.sv
// Arbiter + clear sequencer in front of a 1RW byte-masked memory.
// Define HARD_MEM_ARB_CTRL_INIT_EN to build the post-reset clear sweep.
module hard_mem_1rw_arb_ctrl
  import hard_mem_arb_ctrl_pkg::*;
#(
  parameter int width_p       = 64,
  parameter int els_p         = 512,
  parameter int addr_width_lp = $clog2(els_p),
  parameter int mask_width_lp = width_p >> 3
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  output logic                                 init_done_o,
  input  logic [num_req_lp-1:0]                req_v_i,
  input  logic [num_req_lp-1:0]                req_w_i,
  input  logic [num_req_lp*addr_width_lp-1:0]  req_addr_i,
  input  logic [num_req_lp*width_p-1:0]        req_data_i,
  input  logic [num_req_lp*mask_width_lp-1:0]  req_mask_i,
  output logic [num_req_lp-1:0]                req_ready_o,
  output logic [num_req_lp-1:0]                resp_v_o,
  output logic [width_p-1:0]                   resp_data_o,
  output logic                                 mem_v_o,
  output logic                                 mem_w_o,
  output logic [addr_width_lp-1:0]             mem_addr_o,
  output logic [width_p-1:0]                   mem_data_o,
  output logic [mask_width_lp-1:0]             mem_w_mask_o,
  input  logic [width_p-1:0]                   mem_data_i
);
  logic                     in_init;
  logic [addr_width_lp-1:0] init_addr;
  logic [num_req_lp-1:0]    arb_v, gnt;
  logic                     resp_pend_r, resp_owner_r;

`ifdef HARD_MEM_ARB_CTRL_INIT_EN
  state_e                   state_r, state_n;
  logic [addr_width_lp-1:0] init_cnt_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= e_init;
      init_cnt_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == e_init) init_cnt_r <= init_cnt_r + 1'b1;
    end
  end

  always_comb begin
    state_n = state_r;
    if (state_r == e_init && init_cnt_r == addr_width_lp'(els_p - 1)) state_n = e_run;
  end

  assign in_init   = (state_r == e_init);
  assign init_addr = init_cnt_r;
`else
  assign in_init   = 1'b0;
  assign init_addr = '0;
`endif

  // Requests are invisible to the arbiter while sweeping, so they stay pending.
  assign arb_v = req_v_i & {num_req_lp{~in_init}};

  hard_mem_arb_rr2 u_rr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (arb_v),
    .grant_o (gnt)
  );

  always_comb begin
    req_ready_o  = gnt;
    init_done_o  = ~in_init;
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_w_mask_o = '0;
    if (in_init) begin
      mem_v_o      = 1'b1;
      mem_w_o      = 1'b1;
      mem_addr_o   = init_addr;
      mem_w_mask_o = '1;
    end else begin
      for (int k = 0; k < num_req_lp; k++) begin
        if (gnt[k]) begin
          mem_v_o      = 1'b1;
          mem_w_o      = req_w_i[k];
          mem_addr_o   = req_addr_i[k*addr_width_lp +: addr_width_lp];
          mem_data_o   = req_data_i[k*width_p +: width_p];
          mem_w_mask_o = req_mask_i[k*mask_width_lp +: mask_width_lp];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_pend_r  <= 1'b0;
      resp_owner_r <= 1'b0;
    end else begin
      resp_pend_r <= |(gnt & ~req_w_i);
      if (|(gnt & ~req_w_i)) resp_owner_r <= gnt[1];
    end
  end

  assign resp_v_o    = {resp_pend_r & resp_owner_r, resp_pend_r & ~resp_owner_r};
  assign resp_data_o = mem_data_i;
endmodule

// File: tb/tb_hard_mem_1rw_arb_ctrl.sv
// Randomized + directed bench with a transaction-level memory/arbitration model.
module tb_hard_mem_1rw_arb_ctrl;
  localparam int W = 64, N = 512, A = 9, M = 8;
`ifdef HARD_MEM_ARB_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic clk = 1'b0, reset;
  logic [1:0] req_v, req_w, req_ready, resp_v;
  logic [2*A-1:0] req_addr;
  logic [2*W-1:0] req_data;
  logic [2*M-1:0] req_mask;
  logic init_done, mem_v, mem_w;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_data, mem_rdata, resp_data;
  logic [M-1:0] mem_mask;

  always #5 clk = ~clk;

  hard_mem_1rw_arb_ctrl dut (
    .clk_i(clk), .reset_i(reset), .init_done_o(init_done),
    .req_v_i(req_v), .req_w_i(req_w), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_mask_i(req_mask), .req_ready_o(req_ready), .resp_v_o(resp_v), .resp_data_o(resp_data),
    .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .mem_w_mask_o(mem_mask), .mem_data_i(mem_rdata)
  );

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] nw,
                                         input logic [M-1:0] m);
    logic [W-1:0] r = old;
    for (int b = 0; b < M; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Memory wrapper model: one-cycle read latency, byte-masked writes.
  logic [W-1:0] mem [N];
  logic mem_clr = 1'b0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (mem_v) begin
      if (mem_w) mem[mem_addr] <= merge(mem[mem_addr], mem_data, mem_mask);
      else       mem_rdata <= mem[mem_addr];
    end
  end

  // Reference: expected contents seen from the requester side, arbitration history.
  logic [W-1:0] ref_mem [N];
  int mdl_last, pend, pend_owner;
  logic [W-1:0] pend_data;
  int errors = 0, checks = 0;

  task automatic model_reset(input bit clear_mem);
    mdl_last = 1; pend = 0; pend_owner = 0;
    if (clear_mem) for (int i = 0; i < N; i++) ref_mem[i] = '0;
  endtask

  // One RUN cycle: starts and ends at a negedge.
  task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [A-1:0] a0,
                      input logic [A-1:0] a1, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [M-1:0] m0, input logic [M-1:0] m1,
                      output logic [1:0] got_rdy, output logic [1:0] got_rv,
                      output logic [W-1:0] got_rd);
    logic [1:0] eg, erv;
    int k;
    logic [A-1:0] a; logic [W-1:0] d; logic [M-1:0] m;
    req_v = v; req_w = w; req_addr = {a1, a0}; req_data = {d1, d0}; req_mask = {m1, m0};
    #1;
    got_rdy = req_ready; got_rv = resp_v; got_rd = resp_data;
    if (v == 2'b11) eg = (mdl_last == 1) ? 2'b01 : 2'b10;
    else            eg = v;
    k = eg[1] ? 1 : 0;
    a = k ? a1 : a0; d = k ? d1 : d0; m = k ? m1 : m0;
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got=%b exp=1", init_done); end
    checks++; if (req_ready !== eg) begin errors++; $display("FAIL ready got=%b exp=%b", req_ready, eg); end
    checks++; if (mem_v !== |eg) begin errors++; $display("FAIL mem_v got=%b exp=%b", mem_v, |eg); end
    if (eg != 2'b00) begin
      checks++;
      if (mem_addr !== a || mem_w !== w[k]) begin
        errors++; $display("FAIL mem_cmd got=%0d/%b exp=%0d/%b", mem_addr, mem_w, a, w[k]);
      end
      if (w[k]) begin
        checks++;
        if (mem_data !== d || mem_mask !== m) begin
          errors++; $display("FAIL mem_wdata got=%h/%h exp=%h/%h", mem_data, mem_mask, d, m);
        end
      end
    end
    erv = pend ? (pend_owner ? 2'b10 : 2'b01) : 2'b00;
    checks++; if (resp_v !== erv) begin errors++; $display("FAIL resp_v got=%b exp=%b", resp_v, erv); end
    if (pend) begin
      checks++;
      if (resp_data !== pend_data) begin errors++; $display("FAIL resp_data got=%h exp=%h", resp_data, pend_data); end
    end
    pend = 0;
    if (eg != 2'b00) begin
      if (w[k]) ref_mem[a] = merge(ref_mem[a], d, m);
      else begin pend = 1; pend_owner = k; pend_data = ref_mem[a]; end
      if (v == 2'b11) mdl_last = k;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle();
    logic [1:0] r, rv; logic [W-1:0] rd;
    step(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, r, rv, rd);
  endtask

  // Checks n clear-sweep cycles from address 0; starts/ends at a negedge.
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      checks++;
      if ({mem_v, mem_w, mem_addr, mem_data, mem_mask, init_done, req_ready} !==
          {1'b1, 1'b1, A'(i), {W{1'b0}}, {M{1'b1}}, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL sweep[%0d] got v=%b w=%b a=%0d d=%h m=%h done=%b rdy=%b", i, mem_v, mem_w,
                 mem_addr, mem_data, mem_mask, init_done, req_ready);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clr = 1'b1;
    req_v = '0; req_w = '0; req_addr = '0; req_data = '0; req_mask = '0;
    model_reset(1'b1);
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    #1;
    checks++;
    if (resp_v !== 2'b00 || req_ready !== 2'b00 || init_done !== !INIT_EN || mem_v !== INIT_EN) begin
      errors++;
      $display("FAIL reset got resp=%b rdy=%b done=%b mv=%b exp resp=00 rdy=00 done=%b mv=%b",
               resp_v, req_ready, init_done, mem_v, !INIT_EN, INIT_EN);
    end
    @(negedge clk);
  endtask

  task automatic test_init();
    logic [1:0] r, rv; logic [W-1:0] rd;
    req_v = 2'b01; req_w = 2'b00; req_addr = {A'(0), A'(7)};
    reset = 1'b0;
`ifdef HARD_MEM_ARB_CTRL_INIT_EN
    sweep(N);
`endif
    // request held through the sweep is granted on the first RUN cycle
    step(2'b01, 2'b00, 9'd7, '0, '0, '0, '0, '0, r, rv, rd);
    checks++; if (r !== 2'b01) begin errors++; $display("FAIL first_grant got=%b exp=01", r); end
    idle();
  endtask

  task automatic test_contention();
    logic [1:0] r, rv; logic [W-1:0] rd;
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 2'b00, A'(i + 1), A'(i + 1), '0, '0, '0, '0, r, rv, rd);
      checks++; if (r !== exp_g[i]) begin errors++; $display("FAIL contend[%0d] got=%b exp=%b", i, r, exp_g[i]); end
      if (i > 0) begin
        checks++; if (rv !== exp_g[i-1]) begin errors++; $display("FAIL contend_resp[%0d] got=%b exp=%b", i, rv, exp_g[i-1]); end
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [1:0] r, rv; logic [W-1:0] rd;
    step(2'b01, 2'b01, 9'd5, '0, 64'h1122334455667788, '0, 8'hFF, '0, r, rv, rd);
    step(2'b01, 2'b00, 9'd5, '0, '0, '0, '0, '0, r, rv, rd);
    idle();
    step(2'b10, 2'b10, '0, 9'd5, '0, {W{1'b1}}, '0, 8'h0F, r, rv, rd);
    step(2'b10, 2'b00, '0, 9'd5, '0, '0, '0, '0, r, rv, rd);
    step(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, r, rv, rd);
    checks++;
    if (rv !== 2'b10 || rd !== 64'h11223344FFFFFFFF) begin
      errors++; $display("FAIL mask_read got=%b/%h exp=10/11223344ffffffff", rv, rd);
    end
  endtask

  task automatic test_random();
    logic [1:0] v = '0, w = '0, r, rv;
    logic [A-1:0] a [2]; logic [W-1:0] d [2]; logic [M-1:0] m [2];
    logic [W-1:0] rd;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!v[k] && $urandom_range(0, 3) != 0) begin
          v[k] = 1'b1; w[k] = $urandom_range(0, 1);
          a[k] = A'($urandom_range(0, 15));
          d[k] = {$urandom, $urandom}; m[k] = M'($urandom);
        end
      end
      step(v, w, a[0], a[1], d[0], d[1], m[0], m[1], r, rv, rd);
      v = v & ~r;
    end
    idle();
  endtask

  task automatic test_mid_reset();
    logic [1:0] r, rv; logic [W-1:0] rd;
    step(2'b01, 2'b00, 9'd5, '0, '0, '0, '0, '0, r, rv, rd);
    req_v = 2'b00;
    #2 reset = 1'b1;
    #1;
    checks++; if (resp_v !== 2'b00) begin errors++; $display("FAIL reset_drop got=%b exp=00", resp_v); end
    model_reset(INIT_EN);
    @(negedge clk);
    reset = 1'b0;
`ifdef HARD_MEM_ARB_CTRL_INIT_EN
    sweep(200);
    #1;
    checks++; if (mem_addr !== 9'd200) begin errors++; $display("FAIL sweep_200 got=%0d exp=200", mem_addr); end
    reset = 1'b1;
    #1;
    checks++; if (mem_addr !== 9'd0) begin errors++; $display("FAIL sweep_restart got=%0d exp=0", mem_addr); end
    @(negedge clk);
    reset = 1'b0;
    sweep(N);
`endif
    step(2'b01, 2'b00, 9'd5, '0, '0, '0, '0, '0, r, rv, rd);
    checks++; if (r !== 2'b01) begin errors++; $display("FAIL post_reset_grant got=%b exp=01", r); end
    idle();
  endtask

  initial begin
    test_reset();
    test_init();
    test_contention();
    test_write_read();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hard_mem_1rw_arb_ctrl.md
Name: hard_mem_1rw_arb_ctrl

Overview:
Two-requester arbiter and initialization sequencer in front of one 1RW byte-masked hardened memory wrapper (default 512x64).
- Clears the array after reset.
- Then grants one request per cycle, round-robin, using a valid/ready handshake.
- Routes the one-cycle-latency read data back to the requester that issued the read.
- Sits between the cache/tag logic and the memory wrapper instance.

Parameters:
- width_p, 64, data width in bits (multiple of 8)
- els_p, 512, number of memory entries
- addr_width_lp, $clog2(els_p), address width
- mask_width_lp, width_p>>3, byte-mask width

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- init_done_o  out  1  high once the clear sweep has finished
- req_v_i  in  2  request valid, one bit per requester
- req_w_i  in  2  1 = write, 0 = read
- req_addr_i  in  2*addr_width_lp  request addresses, requester k at slice k
- req_data_i  in  2*width_p  write data
- req_mask_i  in  2*mask_width_lp  byte write enables
- req_ready_o  out  2  grant; a request is accepted when v & ready
- resp_v_o  out  2  read-data-valid pulse, one bit per requester
- resp_data_o  out  width_p  read data (shared by both requesters)
- mem_v_o  out  1  memory access enable
- mem_w_o  out  1  memory write enable
- mem_addr_o  out  addr_width_lp  memory address
- mem_data_o  out  width_p  memory write data
- mem_w_mask_o  out  mask_width_lp  memory byte mask
- mem_data_i  in  width_p  memory read data

Behaviour:
- States: INIT, RUN. Asynchronous reset gives: state = INIT, init_cnt = 0, rr_last = 1 (requester 0 wins the first contention), resp_v_o = 0, resp_owner = 0.
- INIT:
  - req_ready_o = 2'b00 and init_done_o = 0.
  - Each cycle drives mem_v_o = 1, mem_w_o = 1, mem_addr_o = init_cnt, mem_data_o = 0, mem_w_mask_o = all ones, then increments init_cnt.
  - When init_cnt == els_p-1 the write is still issued, and the next state is RUN.
  - The sweep takes exactly els_p cycles.
- RUN:
  - init_done_o = 1.
  - Grant is combinational:
    - only requester k valid: grant k;
    - both valid: grant !rr_last;
    - neither valid: grant none.
  - req_ready_o = one-hot grant and is 0 for a requester that is not valid. A ready never depends on its own requester's later cycles.
  - rr_last updates to the granted index only in cycles where both requesters were valid; a single-requester grant leaves it unchanged.
  - On grant, the granted request's fields pass straight to the mem_* ports in the same cycle with mem_v_o = 1. With no grant, mem_v_o = 0 and the other mem_* outputs are don't-care (driven 0).
- Read response:
  - An accepted read sets resp_v_o[k] = 1 in the next cycle only. resp_owner = k.
  - resp_data_o = mem_data_i, combinational pass-through.
  - There is no backpressure; the requester must sink the pulse.
- Writes produce no response.
- A read and a write can never be in the same cycle: at most one access per cycle.
- Read-after-write to the same address in back-to-back cycles returns the new data.
- Reset asserted mid-operation: any pending response is dropped (resp_v_o goes to 0 immediately), and the sweep restarts from address 0.
- Requests held valid during INIT stay pending and are not lost; the requester must keep its fields stable while v is high and ready is low.

Optional Feature:
- Macro HARD_MEM_ARB_CTRL_INIT_EN.
- Defined: INIT sweep as described above.
- Undefined:
  - Reset goes directly to RUN, and init_done_o = 1 from reset.
  - No init counter is built.
  - Memory contents after reset are undefined.

Decomposition:
- Package hard_mem_arb_ctrl_pkg: state enum (e_init, e_run) and the requester-count constant (2).
- Natural sub-module hard_mem_arb_rr2: a 2-input round-robin arbiter holding rr_last, with inputs v[1:0] and outputs grant[1:0].
- The top level holds the FSM, the init counter, mux selection and response tracking.

Test Plan:
- Reset, no requests (INIT_EN defined) -> exactly 512 cycles of mem writes to addresses 0..511 with data 0 and mask 0xFF; init_done_o rises on cycle 512; req_ready_o = 0 throughout.
- Req0 writes addr 5 = 0x1122334455667788, mask 0xFF; next cycle req0 reads addr 5 -> resp_v_o = 2'b01 one cycle later, resp_data_o = 0x1122334455667788.
- Req1 writes addr 5 = all ones with mask 0x0F, then reads addr 5 -> resp_v_o = 2'b10, data 0x11223344FFFFFFFF.
- Both requesters hold reads valid continuously for 4 cycles -> grants alternate 0,1,0,1; responses alternate 2'b01, 2'b10, each one cycle behind its grant.
- Reset asserted at sweep address 200 -> resp_v_o = 0 immediately; after release the sweep restarts at 0 and completes after 512 more cycles.
- Build without the macro -> init_done_o = 1 and req_ready_o[0] = 1 on the first cycle after reset with req_v_i = 2'b01.
